// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
//   Deserialises a codec-mastered I2S ADC stream into parallel left/right words.
//   All codec pins are asynchronous. They are synchronised and oversampled in the clk domain.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   aud_bclk        codec bit clock (async)
//   aud_adclrck     codec frame clock, 0 = left half, 1 = right half (async)
//   aud_adcdat      codec serial data, MSB first (async)
//   sample_l/_r     last complete left/right word
//   sample_out      sample_l (CHANNEL=0) or sample_r (CHANNEL=1)
//   sample_valid    1-clk pulse per complete stereo pair
//   link_ok         frames arriving; drops after LRCK_TIMEOUT clks without an LRCK edge
//   frame_err       1-clk pulse when a half-frame ends before DATA_WIDTH bits
module i2s_adc_receiver #(
    parameter int DATA_WIDTH   = 16,
    parameter int CHANNEL      = 0,
    parameter int SYNC_STAGES  = 2,
    parameter int LRCK_TIMEOUT = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    output logic [DATA_WIDTH-1:0] sample_l,
    output logic [DATA_WIDTH-1:0] sample_r,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  link_ok,
    output logic                  frame_err
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int TW = $clog2(LRCK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_SEARCH, S_DELAY, S_SHIFT, S_HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
    logic                  r_bclk_prev;
    logic                  r_lrck_last;
    logic                  r_chan;       // channel of the half currently being received
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_left_done;
    logic                  r_pend;       // right word committed after a left word
    logic [TW-1:0]         r_to_cnt;

    logic                  w_bclk_rise, w_lrck, w_dat, w_lr_edge, w_to_hit;
    logic                  w_shifting, w_commit, w_frame_err;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    assign w_bclk_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_prev;
    assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat       = r_dat_sync[SYNC_STAGES-1];
    assign w_lr_edge   = w_bclk_rise && (w_lrck != r_lrck_last);
    // Fires on the clk the counter would step onto LRCK_TIMEOUT; an edge that clk wins.
    assign w_to_hit    = !w_lr_edge && (r_to_cnt == TW'(LRCK_TIMEOUT - 1));

    // The lr_edge bclk_rise is the I2S delay slot, so the first rise seen in DELAY is the MSB.
    assign w_shifting  = w_bclk_rise && !w_lr_edge && !w_to_hit &&
                         (r_state == S_DELAY || r_state == S_SHIFT);
    assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_dat};
    assign w_commit    = w_shifting && (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_frame_err = w_lr_edge && (r_state == S_DELAY || r_state == S_SHIFT);

    assign sample_out  = (CHANNEL == 0) ? sample_l : sample_r;

    always_comb begin
        w_state_nxt = r_state;
        if (w_to_hit) begin
            w_state_nxt = S_SEARCH;
        end else if (w_lr_edge) begin
            // From SEARCH, only the start of a left half locks the receiver.
            if (r_state != S_SEARCH || !w_lrck) w_state_nxt = S_DELAY;
        end else if (w_shifting) begin
            w_state_nxt = w_commit ? S_HOLD : S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_SEARCH;
            r_bclk_sync  <= '0;
            r_lrck_sync  <= '0;
            r_dat_sync   <= '0;
            r_bclk_prev  <= 1'b0;
            r_lrck_last  <= 1'b0;
            r_chan       <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_left_done  <= 1'b0;
            r_pend       <= 1'b0;
            r_to_cnt     <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            link_ok      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], aud_adclrck};
            r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], aud_adcdat};
            r_bclk_prev  <= r_bclk_sync[SYNC_STAGES-1];
            sample_valid <= 1'b0;
            frame_err    <= w_frame_err;

            if (w_bclk_rise) r_lrck_last <= w_lrck;

            if (w_lr_edge)
                r_to_cnt <= '0;
            else if (r_to_cnt != TW'(LRCK_TIMEOUT))
                r_to_cnt <= r_to_cnt + TW'(1);

            if (w_lr_edge) begin
                r_chan    <= w_lrck;
                r_bit_cnt <= '0;
                // A cut-short right half invalidates the pending left word.
                if (w_frame_err && r_chan) r_left_done <= 1'b0;
            end

            if (w_shifting) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end

            if (w_commit) begin
                if (!r_chan) begin
                    sample_l    <= w_shift_nxt;
                    r_left_done <= 1'b1;
                end else begin
                    sample_r    <= w_shift_nxt;
                    r_pend      <= r_left_done;
                end
            end

            if (r_pend) begin
                sample_valid <= 1'b1;
                link_ok      <= 1'b1;
                r_left_done  <= 1'b0;
                r_pend       <= 1'b0;
            end

            if (w_to_hit) begin
                link_ok     <= 1'b0;
                r_left_done <= 1'b0;
                r_pend      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: two instances (CHANNEL=0 and CHANNEL=1) share one
// codec stream. BCLK period is 16 clk; LRCK/DAT change on BCLK falling edges.
module tb_i2s_adc_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
    logic [15:0] s_l, s_r, s_out, s1_l, s1_r, s1_out;
    logic        s_vld, s_lok, s_ferr, s1_vld, s1_lok, s1_ferr;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_lok_at_valid = 0;
    int edge_cyc = 0;
    int b_valid, b_ferr, b_lok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_vld) begin
            n_valid = n_valid + 1;
            if (s_lok) n_lok_at_valid = n_lok_at_valid + 1;
        end
        if (s_ferr) n_ferr = n_ferr + 1;
    end

    i2s_adc_receiver #(.DATA_WIDTH(16), .CHANNEL(0), .SYNC_STAGES(2), .LRCK_TIMEOUT(2048)) dut (
        .clk(clk), .rst(rst), .aud_bclk(bclk), .aud_adclrck(lrck), .aud_adcdat(dat),
        .sample_l(s_l), .sample_r(s_r), .sample_out(s_out),
        .sample_valid(s_vld), .link_ok(s_lok), .frame_err(s_ferr));

    i2s_adc_receiver #(.DATA_WIDTH(16), .CHANNEL(1), .SYNC_STAGES(2), .LRCK_TIMEOUT(2048)) dut1 (
        .clk(clk), .rst(rst), .aud_bclk(bclk), .aud_adclrck(lrck), .aud_adcdat(dat),
        .sample_l(s1_l), .sample_r(s1_r), .sample_out(s1_out),
        .sample_valid(s1_vld), .link_ok(s1_lok), .frame_err(s1_ferr));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One bit period: falling edge with new LRCK/DAT, then rising edge.
    task automatic send_bit(input logic lr, input logic d, input logic mark);
        bclk = 1'b0; lrck = lr; dat = d;
        tick(8);
        bclk = 1'b1;
        if (mark) edge_cyc = cyc;
        tick(8);
    endtask

    // Slot k=0 is the I2S delay bit, k=1..16 carry MSB..LSB, later bits are fill.
    task automatic send_half(input logic lr, input logic [15:0] w, input int slot, input logic fill);
        for (int k = 0; k < slot; k++) begin
            if (k == 0)       send_bit(lr, fill, 1'b1);
            else if (k <= 16) send_bit(lr, w[16-k], 1'b0);
            else              send_bit(lr, fill, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot, input logic fill);
        send_half(1'b0, l, slot, fill);
        send_half(1'b1, r, slot, fill);
    endtask

    task automatic snap();
        b_valid = n_valid; b_ferr = n_ferr; b_lok = n_lok_at_valid;
    endtask

    initial begin
        // Reset values, with the stream already running mid right half.
        tick(1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0);
        chk("rst_sample_l", s_l, 0);
        chk("rst_sample_r", s_r, 0);
        chk("rst_sample_out", s_out, 0);
        chk("rst_sample_out_ch1", s1_out, 0);
        chk("rst_valid", s_vld, 0);
        chk("rst_link_ok", s_lok, 0);
        chk("rst_frame_err", s_ferr, 0);
        snap();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1, 1'b0);
        chk("partial_no_valid", n_valid - b_valid, 0);

        // Nominal 32-bit slots.
        send_frame(16'hA5C3, 16'h1234, 32, 1'b0);
        send_frame(16'hA5C3, 16'h1234, 32, 1'b0);
        chk("nom_valid_count", n_valid - b_valid, 2);
        chk("nom_ferr_count", n_ferr - b_ferr, 0);
        chk("nom_sample_l", s_l, 32'hA5C3);
        chk("nom_sample_r", s_r, 32'h1234);
        chk("nom_sample_out", s_out, 32'hA5C3);
        chk("nom_sample_out_ch1", s1_out, 32'h1234);
        chk("nom_link_ok", s_lok, 1);

        // Left half of only 10 BCLKs.
        snap();
        send_half(1'b0, 16'h0F0F, 10, 1'b0);
        send_half(1'b1, 16'h5555, 32, 1'b0);
        chk("short_ferr_count", n_ferr - b_ferr, 1);
        chk("short_valid_count", n_valid - b_valid, 0);
        chk("short_sample_l_kept", s_l, 32'hA5C3);
        chk("short_sample_r", s_r, 32'h5555);
        send_frame(16'h0102, 16'h0304, 32, 1'b0);
        chk("recover_valid_count", n_valid - b_valid, 1);
        chk("recover_ferr_count", n_ferr - b_ferr, 1);
        chk("recover_sample_l", s_l, 32'h0102);

        // Timeout: edge_cyc is the cycle of the last lr_edge's BCLK rise on the pin.
        // That edge is seen 3 clks later, so link_ok drops 2048+3 clks after it.
        while (cyc < edge_cyc + 2050) tick(1);
        chk("timeout_before", s_lok, 1);
        tick(1);
        chk("timeout_at", s_lok, 0);
        chk("timeout_sample_l_kept", s_l, 32'h0102);

        // Restart with 24-bit slots, trailing 1s, extreme values.
        snap();
        send_frame(16'h8000, 16'h7FFF, 24, 1'b1);
        chk("ext_valid_count", n_valid - b_valid, 1);
        chk("ext_link_ok_at_valid", n_lok_at_valid - b_lok, 1);
        chk("ext_sample_l", s_l, 32'h8000);
        chk("ext_sample_r", s_r, 32'h7FFF);
        chk("ext_sample_out", s_out, 32'h8000);
        chk("ext_sample_out_ch1", s1_out, 32'h7FFF);

        // One-clk reset mid SHIFT.
        snap();
        send_bit(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_sample_l", s_l, 0);
        chk("midrst_sample_r", s_r, 0);
        chk("midrst_sample_out_ch1", s1_out, 0);
        chk("midrst_link_ok", s_lok, 0);
        chk("midrst_valid", s_vld, 0);
        chk("midrst_frame_err", s_ferr, 0);
        for (int i = 0; i < 11; i++) send_bit(1'b0, 1'b1, 1'b0);
        send_half(1'b1, 16'hFFFF, 32, 1'b0);
        chk("midrst_no_valid", n_valid - b_valid, 0);
        send_frame(16'h1357, 16'h2468, 32, 1'b0);
        chk("resume_valid_count", n_valid - b_valid, 1);
        chk("resume_ferr_count", n_ferr - b_ferr, 0);
        chk("resume_sample_l", s_l, 32'h1357);
        chk("resume_sample_r", s_r, 32'h2468);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
